pll_reset_ce_gen: RTL and testbench
===================================

// Module: pll_reset_ce_gen
// PURPOSE
//  Sits directly downstream of the core PLL, in the clk_sys (80 MHz PLL output) domain.
//  Synchronises the asynchronous PLL lock flag and holds the core in reset for a fixed time after lock.
//  Generates single-cycle clock enables at /2, /4, /8 and /16 of clk_sys for the core's slower logic.
//  Re-asserts core reset on lock loss or soft reset.
// PARAMETERS
//  SYNC_STAGES  2     flops in pll_locked synchroniser (>=2)
//  HOLD_CYCLES  1024  clk_sys cycles core_reset stays high after synced lock (>=1)
//  NUM_CE       4     clock-enable outputs; ce[k] divides clk_sys by 2^(k+1)
// PORTS
//  clk_sys        in   1       system clock, single clock domain
//  reset          in   1       synchronous, active-high block reset
//  pll_locked     in   1       PLL lock flag, asynchronous to clk_sys
//  soft_rst       in   1       synchronous request to restart the hold period (OSD/user reset)
//  core_reset     out  1       registered, active-high reset to downstream core
//  ce             out  NUM_CE  clock-enable pulses, one clk_sys cycle wide
//  lock_loss_cnt  out  8       saturating lock-loss count (only with LOCK_LOSS_CNT_EN)
// BEHAVIOUR
//  Reset (reset=1 at edge): sync chain=0, state=WAIT_LOCK, hold_cnt=0, div_cnt=0,
//   core_reset=1, ce=0, lock_loss_cnt=0. All outputs hold these values while reset=1.
//  lock_s = last flop of SYNC_STAGES chain sampling pll_locked.
//  FSM (registered), priority: lock loss > soft_rst > normal:
//   WAIT_LOCK: core_reset=1; lock_s=1 -> HOLD, hold_cnt<=0.
//   HOLD: core_reset=1; lock_s=0 -> WAIT_LOCK; soft_rst=1 -> stay HOLD, hold_cnt<=0;
//    else hold_cnt++; at hold_cnt==HOLD_CYCLES-1 -> RUN.
//   RUN: core_reset=0; lock_s=0 -> WAIT_LOCK; soft_rst=1 -> HOLD, hold_cnt<=0.
//  core_reset registered as (next_state != RUN): falls on the same edge that enters RUN,
//   rises on the same edge that leaves RUN.
//  Latency: counting edge 1 as first edge sampling pll_locked=1, core_reset falls at edge
//   SYNC_STAGES+HOLD_CYCLES+1 (no soft_rst, stable lock).
//  hold_cnt width $clog2(HOLD_CYCLES+1); never exceeds HOLD_CYCLES-1.
//  div_cnt: NUM_CE bits, cleared whenever state!=RUN, increments each RUN cycle, wraps 2^NUM_CE-1 -> 0.
//  ce[k] = (state==RUN) && (div_cnt[k:0] == all ones); combinational decode of registers only.
//   ce[0] first high on 2nd RUN cycle; ce[NUM_CE-1] on the 2^NUM_CE-th RUN cycle.
//   Every ce[k] pulse coincides with a ce[k-1] pulse (nested enables).
//  ce=0 in WAIT_LOCK/HOLD; on leaving RUN, ce drops to 0 the cycle state changes, phase restarts.
//  Glitch on pll_locked shorter than one clk_sys period may be missed; no filtering required.
//  soft_rst held high keeps FSM in HOLD with hold_cnt=0 (core_reset stays 1).
// CONFIGURATION
//  LOCK_LOSS_CNT_EN defined: port lock_loss_cnt exists; 8-bit counter increments on every
//   RUN->WAIT_LOCK transition, saturates at 255, cleared only by reset. HOLD->WAIT_LOCK not counted.
//  LOCK_LOSS_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (SYNC_STAGES=2, HOLD_CYCLES=16, NUM_CE=4)
//  Power-up: reset 3 cycles, pll_locked=1 from edge 1 after reset -> core_reset falls at edge 19, ce=0 before.
//  CE cadence in RUN for 64 cycles -> ce[0] 32 pulses, ce[1] 16, ce[2] 8, ce[3] 4; ce[3] at RUN cycles 16,32,48,64.
//  pll_locked drops for 5 cycles in RUN -> core_reset=1 2 edges later (sync+FSM), ce=0; relock -> 19 edges to RUN.
//  soft_rst 1-cycle pulse in RUN -> core_reset=1 next edge, back to 0 exactly 16 edges later; lock stays 1.
//  reset asserted mid-HOLD (hold_cnt=7) -> all outputs to reset values next edge; full 19-edge sequence repeats.
//  LOCK_LOSS_CNT_EN: 300 RUN->lock-loss->RUN cycles -> lock_loss_cnt=255; lock loss during HOLD -> no increment.

Source files
------------

// File: rtl/pll_reset_ce_gen.sv
// Post-PLL reset sequencer and clock-enable generator for the clk_sys domain.
// Optional 8-bit saturating lock-loss counter enabled by defining LOCK_LOSS_CNT_EN.
module pll_reset_ce_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int NUM_CE      = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              soft_rst,
  output logic              core_reset,
  output logic [NUM_CE-1:0] ce
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]        lock_loss_cnt
`endif
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  state_t                 state_r;
  state_t                 next_state_s;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [HOLD_W-1:0]      hold_cnt_next_s;
  logic [NUM_CE-1:0]      div_cnt_r;
  logic                   core_reset_r;
  logic                   core_reset_next_s;
  logic [NUM_CE-1:0]      ce_s;

  // Nested enable decode: ce[k] needs every low-order divider bit up to k set.
  function automatic logic [NUM_CE-1:0] ce_decode(input logic run, input logic [NUM_CE-1:0] div);
    logic acc;
    ce_decode = '0;
    acc = run;
    for (int k = 0; k < NUM_CE; k++) begin
      acc = acc & div[k];
      ce_decode[k] = acc;
    end
  endfunction

  // Lock flag synchroniser chain.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = sync_r[SYNC_STAGES-1];

  // FSM state and hold-period counter registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r    <= WAIT_LOCK;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= next_state_s;
      hold_cnt_r <= hold_cnt_next_s;
    end
  end

  // Next-state logic; lock loss outranks soft reset in every state.
  always_comb begin
    next_state_s    = state_r;
    hold_cnt_next_s = hold_cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) begin
          next_state_s    = HOLD;
          hold_cnt_next_s = '0;
        end else begin
          next_state_s    = WAIT_LOCK;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          next_state_s    = WAIT_LOCK;
          hold_cnt_next_s = '0;
        end else if (soft_rst) begin
          next_state_s    = HOLD;
          hold_cnt_next_s = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          next_state_s    = RUN;
          hold_cnt_next_s = '0;
        end else begin
          next_state_s    = HOLD;
          hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state_s    = WAIT_LOCK;
          hold_cnt_next_s = '0;
        end else if (soft_rst) begin
          next_state_s    = HOLD;
          hold_cnt_next_s = '0;
        end else begin
          next_state_s    = RUN;
        end
      end
      default: begin
        next_state_s    = WAIT_LOCK;
        hold_cnt_next_s = '0;
      end
    endcase
  end

  // Output decode: reset follows the upcoming state so it toggles on the RUN entry/exit edge.
  always_comb begin
    core_reset_next_s = 1'b1;
    if (next_state_s == RUN) begin
      core_reset_next_s = 1'b0;
    end else begin
      core_reset_next_s = 1'b1;
    end
    ce_s = ce_decode(state_r == RUN, div_cnt_r);
  end

  // Registered core reset and enable-phase divider.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      core_reset_r <= 1'b1;
      div_cnt_r    <= '0;
    end else begin
      core_reset_r <= core_reset_next_s;
      if (state_r == RUN) begin
        div_cnt_r <= div_cnt_r + NUM_CE'(1);
      end else begin
        div_cnt_r <= '0;
      end
    end
  end

  assign core_reset = core_reset_r;
  assign ce         = ce_s;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt_r;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lock_loss_cnt_r <= 8'd0;
    end else if ((state_r == RUN) && (next_state_s == WAIT_LOCK) && (lock_loss_cnt_r != 8'hFF)) begin
      lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
    end else begin
      lock_loss_cnt_r <= lock_loss_cnt_r;
    end
  end

  assign lock_loss_cnt = lock_loss_cnt_r;
`endif

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed + randomized bench for pll_reset_ce_gen against a cycle-level behavioural model.
// Covers the lock-loss counter too when LOCK_LOSS_CNT_EN is defined.
module tb_pll_reset_ce_gen;
  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int NCE  = 4;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic           pll_locked;
  logic           soft_rst;
  logic           core_reset;
  logic [NCE-1:0] ce;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0]     lock_loss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  pll_reset_ce_gen #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .NUM_CE(NCE)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .pll_locked(pll_locked),
    .soft_rst(soft_rst),
    .core_reset(core_reset),
    .ce(ce)
`ifdef LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  // Model: phase 0 = waiting for lock, 1 = holding, 2 = running.
  logic [SYNC-1:0] m_hist;
  int m_phase;
  int m_elapsed;
  int m_run;
`ifdef LOCK_LOSS_CNT_EN
  int m_losses;
`endif

  task automatic model_edge();
    logic ls;
    ls = m_hist[SYNC-1];
    if (reset) begin
      m_hist = '0; m_phase = 0; m_elapsed = 0; m_run = 0;
`ifdef LOCK_LOSS_CNT_EN
      m_losses = 0;
`endif
    end else begin
      m_hist = {m_hist[SYNC-2:0], pll_locked};
      if (m_phase == 0) begin
        if (ls) begin m_phase = 1; m_elapsed = 0; end
      end else if (m_phase == 1) begin
        if (!ls) m_phase = 0;
        else if (soft_rst) m_elapsed = 0;
        else if (m_elapsed == HOLD - 1) begin m_phase = 2; m_run = 0; end
        else m_elapsed++;
      end else begin
        if (!ls) begin
          m_phase = 0;
`ifdef LOCK_LOSS_CNT_EN
          if (m_losses < 255) m_losses++;
`endif
        end else if (soft_rst) begin m_phase = 1; m_elapsed = 0; end
        else m_run++;
      end
    end
  endtask

  function automatic logic [NCE-1:0] exp_ce();
    exp_ce = '0;
    for (int k = 0; k < NCE; k++)
      exp_ce[k] = (m_phase == 2) && (((m_run + 1) % (1 << (k + 1))) == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    check("model_core_reset", core_reset, (m_phase != 2) ? 32'd1 : 32'd0);
    check("model_ce", ce, exp_ce());
`ifdef LOCK_LOSS_CNT_EN
    check("model_lock_loss_cnt", lock_loss_cnt, m_losses);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt[NCE];
    int exp_cnt[NCE];
    int r;
    exp_cnt = '{32, 16, 8, 4};
    reset = 1'b1; pll_locked = 1'b0; soft_rst = 1'b0;
    m_hist = '0; m_phase = 0; m_elapsed = 0; m_run = 0;
`ifdef LOCK_LOSS_CNT_EN
    m_losses = 0;
`endif

    // Power-up: reset three cycles, then lock from the first edge after reset.
    ticks(3);
    check("reset_core_reset", core_reset, 1);
    check("reset_ce", ce, 0);
    reset = 1'b0; pll_locked = 1'b1;
    ticks(18);
    check("pwrup_edge18_reset", core_reset, 1);
    check("pwrup_edge18_ce", ce, 0);
    tick();
    check("pwrup_edge19_fall", core_reset, 0);

    // Enable cadence over the first 64 RUN cycles.
    for (int k = 0; k < NCE; k++) cnt[k] = 0;
    for (int c = 1; c <= 64; c++) begin
      if (c > 1) tick();
      for (int k = 0; k < NCE; k++) if (ce[k]) cnt[k]++;
      check("ce3_position", ce[3], (c % 16) == 0);
      check("ce_nested", ce[3] & ~ce[2], 0);
    end
    for (int k = 0; k < NCE; k++) check("ce_pulse_count", cnt[k], exp_cnt[k]);

    // Lock dropped for five cycles, then relock.
    pll_locked = 1'b0;
    ticks(3);
    check("lockloss_core_reset", core_reset, 1);
    check("lockloss_ce", ce, 0);
    ticks(2);
    pll_locked = 1'b1;
    ticks(18);
    check("relock_edge18", core_reset, 1);
    tick();
    check("relock_edge19", core_reset, 0);

    // Single-cycle soft reset in RUN.
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    check("soft_rise", core_reset, 1);
    ticks(15);
    check("soft_edge15", core_reset, 1);
    tick();
    check("soft_edge16_fall", core_reset, 0);

    // Soft reset held keeps the block in HOLD.
    soft_rst = 1'b1; ticks(40);
    check("soft_held", core_reset, 1);
    soft_rst = 1'b0; ticks(15);
    check("soft_release_15", core_reset, 1);
    tick();
    check("soft_release_16", core_reset, 0);

    // Reset asserted mid-HOLD with the hold counter at 7.
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    ticks(7);
    reset = 1'b1; tick();
    check("midhold_reset_core", core_reset, 1);
    check("midhold_reset_ce", ce, 0);
    tick();
    reset = 1'b0;
    ticks(18);
    check("midhold_edge18", core_reset, 1);
    tick();
    check("midhold_edge19", core_reset, 0);

    // Randomized mix of lock glitches, soft resets, resets and idle time.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: begin pll_locked = 1'b0; ticks($urandom_range(1, 6)); pll_locked = 1'b1; end
        1: begin soft_rst = 1'b1; tick(); soft_rst = 1'b0; end
        2: ticks($urandom_range(1, 30));
        3: begin reset = 1'b1; ticks($urandom_range(1, 3)); reset = 1'b0; end
        default: begin
          for (int j = 0; j < 10; j++) begin
            pll_locked = ($urandom_range(0, 7) != 0);
            soft_rst   = ($urandom_range(0, 5) == 0);
            tick();
          end
          pll_locked = 1'b1; soft_rst = 1'b0;
        end
      endcase
      ticks(25);
    end

`ifdef LOCK_LOSS_CNT_EN
    // Lock-loss counter: HOLD-time loss not counted, then saturation.
    reset = 1'b1; tick(); reset = 1'b0; pll_locked = 1'b1;
    ticks(19);
    pll_locked = 1'b0; ticks(3); pll_locked = 1'b1;
    check("llc_one", lock_loss_cnt, 1);
    ticks(6);
    pll_locked = 1'b0; ticks(3); pll_locked = 1'b1;
    check("llc_hold_not_counted", lock_loss_cnt, 1);
    ticks(20);
    for (int it = 0; it < 300; it++) begin
      pll_locked = 1'b0; ticks(3); pll_locked = 1'b1; ticks(20);
    end
    check("llc_saturated", lock_loss_cnt, 255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
